// File: rtl/apb_uart_fifo_if.sv
// APB3 slave bus bundle for apb_uart_fifo.
// Signal names follow the APB3 convention so the bus matches the peripheral fabric.
interface apb_uart_fifo_if;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [4:0]  PADDR;
    logic [15:0] PWDATA;
    logic [15:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/apb_uart_fifo.sv
// APB3 UART with TX/RX FIFOs, 16x oversampled receiver, sticky error flags and level IRQ.
// Optional parity (PEN/PODD at 0x10[7:6]) is built when UART_PARITY_EN is defined.
module apb_uart_fifo #(
    parameter int          DATA_WIDTH = 8,
    parameter int          TX_DEPTH   = 16,
    parameter int          RX_DEPTH   = 16,
    parameter logic [15:0] BAUD_RST   = 16'd1
) (
    input  logic           PCLK,
    input  logic           PRESET,
    apb_uart_fifo_if.slave apb,
    input  logic           RX,
    output logic           TX,
    output logic           IRQ
);
    localparam int TXAW = $clog2(TX_DEPTH);
    localparam int RXAW = $clog2(RX_DEPTH);
    localparam logic [2:0] LAST_BIT = 3'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} uart_st_t;

    logic [15:0]           r_baud, r_baud_cnt;
    logic [DATA_WIDTH-1:0] r_tx_mem [TX_DEPTH];
    logic [DATA_WIDTH-1:0] r_rx_mem [RX_DEPTH];
    logic [TXAW-1:0]       r_tx_wr, r_tx_rd;
    logic [RXAW-1:0]       r_rx_wr, r_rx_rd;
    logic [TXAW:0]         r_tx_cnt;
    logic [RXAW:0]         r_rx_cnt;
    logic [5:0]            r_ie;
    logic                  r_ovf, r_ferr;
    uart_st_t              r_tx_st, r_rx_st;
    logic [3:0]            r_tx_os, r_rx_os;
    logic [2:0]            r_tx_bit, r_rx_bit;
    logic [DATA_WIDTH-1:0] r_tx_data, r_rx_data;
    logic                  r_tx, r_rx_s1, r_rx_s2, r_rx_s3, r_rx_pbit;

    logic        w_xfer, w_err, w_ok_wr, w_ok_rd, w_tick;
    logic [2:0]  w_idx;
    logic        w_tx_full, w_tx_empty, w_rx_full, w_rx_empty;
    logic        w_tx_push, w_tx_pop, w_rx_push, w_rx_pop;
    logic        w_baud_wr, w_ie_wr, w_stat_rd, w_rx_done, w_rx_fall, w_tx_idle;
    logic        w_pen, w_podd, w_perr;
    logic [5:0]  w_status, w_ie_mask;
    logic [15:0] w_rdata;
    logic        w_unused;

    assign w_xfer     = apb.PSEL & apb.PENABLE;
    assign w_idx      = apb.PADDR[4:2];
    assign w_tx_full  = (r_tx_cnt == (TXAW+1)'(TX_DEPTH));
    assign w_tx_empty = (r_tx_cnt == '0);
    assign w_rx_full  = (r_rx_cnt == (RXAW+1)'(RX_DEPTH));
    assign w_rx_empty = (r_rx_cnt == '0);

    // Errored accesses are squashed so they leave every register untouched.
    assign w_err = w_xfer & ((w_idx >= 3'd5) |
                   (apb.PWRITE & ((w_idx == 3'd0 & w_tx_full) | w_idx == 3'd1 | w_idx == 3'd2)));
    assign w_ok_wr   = w_xfer & apb.PWRITE & ~w_err;
    assign w_ok_rd   = w_xfer & ~apb.PWRITE & ~w_err;
    assign w_tx_push = w_ok_wr & (w_idx == 3'd0);
    assign w_baud_wr = w_ok_wr & (w_idx == 3'd3);
    assign w_ie_wr   = w_ok_wr & (w_idx == 3'd4);
    assign w_rx_pop  = w_ok_rd & (w_idx == 3'd1) & ~w_rx_empty;
    assign w_stat_rd = w_ok_rd & (w_idx == 3'd2);

    assign w_tx_idle = (r_tx_st == S_IDLE) & w_tx_empty;
    assign w_status  = {w_tx_idle, w_perr, r_ferr, r_ovf, ~w_rx_empty, ~w_tx_full};
    assign IRQ       = |(w_status & r_ie & w_ie_mask);
    assign TX        = r_tx;

    always_comb begin
        w_rdata = '0;
        if (w_ok_rd) begin
            case (w_idx)
                3'd1:    w_rdata = w_rx_empty ? 16'd0 : 16'(r_rx_mem[r_rx_rd]);
                3'd2:    w_rdata = {10'd0, w_status};
                3'd3:    w_rdata = r_baud;
                3'd4:    w_rdata = {8'd0, w_pen, w_podd, r_ie & w_ie_mask};
                default: w_rdata = '0;
            endcase
        end
    end

    assign apb.PRDATA  = PRESET ? 16'd0 : w_rdata;
    assign apb.PSLVERR = ~PRESET & w_err;
    assign apb.PREADY  = 1'b1;

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_baud     <= BAUD_RST;
            r_baud_cnt <= BAUD_RST;
            r_ie       <= '0;
        end else begin
            if (w_baud_wr) r_baud <= apb.PWDATA;
            if (w_ie_wr)   r_ie   <= apb.PWDATA[5:0];
            if (w_baud_wr)   r_baud_cnt <= apb.PWDATA;
            else if (w_tick) r_baud_cnt <= r_baud;
            else             r_baud_cnt <= r_baud_cnt - 16'd1;
        end
    end
    assign w_tick = (r_baud_cnt == 16'd0);

    always_ff @(posedge PCLK) begin
        if (w_tx_push) r_tx_mem[r_tx_wr] <= apb.PWDATA[DATA_WIDTH-1:0];
        if (w_rx_push) r_rx_mem[r_rx_wr] <= r_rx_data;
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_tx_wr <= '0; r_tx_rd <= '0; r_tx_cnt <= '0;
            r_rx_wr <= '0; r_rx_rd <= '0; r_rx_cnt <= '0;
            r_ovf   <= 1'b0; r_ferr <= 1'b0;
        end else begin
            if (w_tx_push) r_tx_wr <= r_tx_wr + 1'b1;
            if (w_tx_pop)  r_tx_rd <= r_tx_rd + 1'b1;
            if (w_rx_push) r_rx_wr <= r_rx_wr + 1'b1;
            if (w_rx_pop)  r_rx_rd <= r_rx_rd + 1'b1;
            r_tx_cnt <= r_tx_cnt + {{TXAW{1'b0}}, w_tx_push} - {{TXAW{1'b0}}, w_tx_pop};
            r_rx_cnt <= r_rx_cnt + {{RXAW{1'b0}}, w_rx_push} - {{RXAW{1'b0}}, w_rx_pop};
            // A new event in the same cycle as a STATUS read survives the clear.
            r_ovf  <= (r_ovf  & ~w_stat_rd) | (w_rx_done & r_rx_s2 & w_rx_full);
            r_ferr <= (r_ferr & ~w_stat_rd) | (w_rx_done & ~r_rx_s2);
        end
    end

`ifdef UART_PARITY_EN
    logic r_pen, r_podd, r_perr;
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_pen <= 1'b0; r_podd <= 1'b0; r_perr <= 1'b0;
        end else begin
            if (w_ie_wr) begin
                r_pen  <= apb.PWDATA[7];
                r_podd <= apb.PWDATA[6];
            end
            r_perr <= (r_perr & ~w_stat_rd) |
                      (w_rx_done & r_rx_s2 & r_pen & ((^r_rx_data ^ r_podd) != r_rx_pbit));
        end
    end
    assign w_pen = r_pen;
    assign w_podd = r_podd;
    assign w_perr = r_perr;
    assign w_ie_mask = 6'h3F;
`else
    assign w_pen = 1'b0;
    assign w_podd = 1'b0;
    assign w_perr = 1'b0;
    assign w_ie_mask = 6'h2F;
`endif

    // A new frame starts straight out of the last stop tick, so frames run back to back.
    assign w_tx_pop = w_tick & ~w_tx_empty &
                      ((r_tx_st == S_IDLE) | (r_tx_st == S_STOP & r_tx_os == 4'd15));

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_tx_st <= S_IDLE; r_tx <= 1'b1; r_tx_os <= '0; r_tx_bit <= '0; r_tx_data <= '0;
        end else if (w_tick) begin
            if (w_tx_pop) begin
                r_tx_st   <= S_START;
                r_tx      <= 1'b0;
                r_tx_os   <= '0;
                r_tx_data <= r_tx_mem[r_tx_rd];
            end else if (r_tx_st != S_IDLE) begin
                r_tx_os <= r_tx_os + 4'd1;
                if (r_tx_os == 4'd15) begin
                    case (r_tx_st)
                        S_START: begin r_tx_st <= S_DATA; r_tx_bit <= '0; r_tx <= r_tx_data[0]; end
                        S_DATA: begin
                            if (r_tx_bit == LAST_BIT) begin
                                r_tx_st <= w_pen ? S_PAR : S_STOP;
                                r_tx    <= w_pen ? (^r_tx_data ^ w_podd) : 1'b1;
                            end else begin
                                r_tx_bit <= r_tx_bit + 3'd1;
                                r_tx     <= r_tx_data[r_tx_bit + 3'd1];
                            end
                        end
                        S_PAR:   begin r_tx_st <= S_STOP; r_tx <= 1'b1; end
                        default: r_tx_st <= S_IDLE;
                    endcase
                end
            end
        end
    end

    assign w_rx_fall = r_rx_s3 & ~r_rx_s2;
    assign w_rx_done = (r_rx_st == S_STOP) & w_tick & (r_rx_os == 4'd15);
    assign w_rx_push = w_rx_done & r_rx_s2 & ~w_rx_full;

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_rx_s1 <= 1'b1; r_rx_s2 <= 1'b1; r_rx_s3 <= 1'b1;
            r_rx_st <= S_IDLE; r_rx_os <= '0; r_rx_bit <= '0; r_rx_data <= '0; r_rx_pbit <= 1'b0;
        end else begin
            r_rx_s1 <= RX;
            r_rx_s2 <= r_rx_s1;
            r_rx_s3 <= r_rx_s2;
            case (r_rx_st)
                S_IDLE: if (w_rx_fall) begin r_rx_st <= S_START; r_rx_os <= '0; end
                S_START: if (w_tick) begin
                    if (r_rx_os == 4'd7) begin
                        r_rx_os  <= '0;
                        r_rx_bit <= '0;
                        r_rx_st  <= r_rx_s2 ? S_IDLE : S_DATA;
                    end else begin
                        r_rx_os <= r_rx_os + 4'd1;
                    end
                end
                default: if (w_tick) begin
                    r_rx_os <= r_rx_os + 4'd1;
                    if (r_rx_os == 4'd15) begin
                        case (r_rx_st)
                            S_DATA: begin
                                r_rx_data[r_rx_bit] <= r_rx_s2;
                                if (r_rx_bit == LAST_BIT) r_rx_st <= w_pen ? S_PAR : S_STOP;
                                else                      r_rx_bit <= r_rx_bit + 3'd1;
                            end
                            S_PAR:   begin r_rx_pbit <= r_rx_s2; r_rx_st <= S_STOP; end
                            default: r_rx_st <= S_IDLE;
                        endcase
                    end
                end
            endcase
        end
    end

    assign w_unused = ^{apb.PADDR[1:0], r_rx_pbit};
endmodule

// File: tb/tb_apb_uart_fifo.sv
// Directed bench for apb_uart_fifo: register vector table plus serial TX/RX sequences.
// Parity sequence is compiled in only when UART_PARITY_EN is defined.
module tb_apb_uart_fifo;
    logic PCLK = 1'b0;
    logic PRESET;
    logic rx_drv, loop;
    logic rx_line, TX, IRQ;
    int   total = 0;
    int   bad = 0;

    apb_uart_fifo_if bus();

    assign rx_line = loop ? TX : rx_drv;

    apb_uart_fifo #(.DATA_WIDTH(8), .TX_DEPTH(16), .RX_DEPTH(16), .BAUD_RST(16'd1)) dut (
        .PCLK(PCLK), .PRESET(PRESET), .apb(bus.slave), .RX(rx_line), .TX(TX), .IRQ(IRQ)
    );

    always #5 PCLK = ~PCLK;

    localparam logic [15:0] IE_RB =
`ifdef UART_PARITY_EN
        16'h00FF;
`else
        16'h002F;
`endif

    typedef struct {
        logic        wr;
        logic [4:0]  addr;
        logic [15:0] wd;
        logic [15:0] exp_rd;
        logic        exp_err;
        logic        chk_rd;
    } vec_t;

    vec_t v[15];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic apb(input logic wr, input logic [4:0] a, input logic [15:0] wd,
                       output logic [15:0] rd, output logic er);
        @(negedge PCLK);
        bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = wr; bus.PADDR = a; bus.PWDATA = wd;
        @(negedge PCLK);
        bus.PENABLE = 1'b1;
        #1;
        rd = bus.PRDATA;
        er = bus.PSLVERR;
        @(negedge PCLK);
        bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0;
    endtask

    task automatic wr(input logic [4:0] a, input logic [15:0] d, input string nm);
        logic [15:0] r;
        logic e;
        apb(1'b1, a, d, r, e);
        chk({nm, "_err"}, e, 1'b0);
    endtask

    task automatic rd(input logic [4:0] a, input logic [15:0] exp, input string nm);
        logic [15:0] r;
        logic e;
        apb(1'b0, a, 16'h0, r, e);
        chk(nm, r, exp);
    endtask

    task automatic do_reset();
        @(negedge PCLK);
        PRESET = 1'b1;
        repeat (3) @(negedge PCLK);
        PRESET = 1'b0;
    endtask

    // Bit time is 16 PCLK: used with BAUD=0.
    task automatic send_rx(input logic [7:0] d, input logic use_par, input logic pb, input logic stop);
        rx_drv = 1'b0;
        repeat (16) @(negedge PCLK);
        for (int i = 0; i < 8; i++) begin
            rx_drv = d[i];
            repeat (16) @(negedge PCLK);
        end
        if (use_par) begin
            rx_drv = pb;
            repeat (16) @(negedge PCLK);
        end
        rx_drv = stop;
        repeat (16) @(negedge PCLK);
        rx_drv = 1'b1;
        repeat (20) @(negedge PCLK);
    endtask

    initial begin
        logic [15:0] r;
        logic        e;
        logic        seen;
        int          len;
        logic [7:0]  pat;

        PRESET = 1'b1; loop = 1'b0; rx_drv = 1'b1;
        bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0; bus.PADDR = '0; bus.PWDATA = '0;
        repeat (3) @(negedge PCLK);
        chk("rst_tx", TX, 1'b1);
        chk("rst_irq", IRQ, 1'b0);
        chk("rst_prdata", bus.PRDATA, 16'h0);
        chk("rst_pslverr", bus.PSLVERR, 1'b0);
        PRESET = 1'b0;

        // wr, addr, wdata, expected rdata, expected PSLVERR, check rdata
        v[0]  = '{1'b0, 5'h08, 16'h0000, 16'h0021, 1'b0, 1'b1};
        v[1]  = '{1'b0, 5'h0C, 16'h0000, 16'h0001, 1'b0, 1'b1};
        v[2]  = '{1'b0, 5'h10, 16'h0000, 16'h0000, 1'b0, 1'b1};
        v[3]  = '{1'b0, 5'h04, 16'h0000, 16'h0000, 1'b0, 1'b1};
        v[4]  = '{1'b1, 5'h0C, 16'h1234, 16'h0000, 1'b0, 1'b0};
        v[5]  = '{1'b0, 5'h0C, 16'h0000, 16'h1234, 1'b0, 1'b1};
        v[6]  = '{1'b1, 5'h10, 16'h00FF, 16'h0000, 1'b0, 1'b0};
        v[7]  = '{1'b0, 5'h10, 16'h0000, IE_RB,    1'b0, 1'b1};
        v[8]  = '{1'b1, 5'h04, 16'hAAAA, 16'h0000, 1'b1, 1'b0};
        v[9]  = '{1'b1, 5'h08, 16'hFFFF, 16'h0000, 1'b1, 1'b0};
        v[10] = '{1'b0, 5'h14, 16'h0000, 16'h0000, 1'b1, 1'b1};
        v[11] = '{1'b1, 5'h18, 16'h0001, 16'h0000, 1'b1, 1'b0};
        v[12] = '{1'b0, 5'h1C, 16'h0000, 16'h0000, 1'b1, 1'b1};
        v[13] = '{1'b0, 5'h0C, 16'h0000, 16'h1234, 1'b0, 1'b1};
        v[14] = '{1'b0, 5'h00, 16'h0000, 16'h0000, 1'b0, 1'b1};

        for (int i = 0; i < 15; i++) begin
            apb(v[i].wr, v[i].addr, v[i].wd, r, e);
            chk($sformatf("vec%0d_err", i), e, v[i].exp_err);
            if (v[i].chk_rd) chk($sformatf("vec%0d_rd", i), r, v[i].exp_rd);
        end
        chk("irq_txrdy", IRQ, 1'b1);

        do_reset();
        chk("rst2_irq", IRQ, 1'b0);
        rd(5'h10, 16'h0000, "rst2_ie");
        rd(5'h0C, 16'h0001, "rst2_baud");

        // Single 0x55 frame at BAUD=3: 64 PCLK per bit.
        wr(5'h0C, 16'd3, "t1_baud");
        wr(5'h00, 16'h0055, "t1_tx");
        seen = 1'b0;
        for (int i = 0; i < 600 && !seen; i++) begin
            @(negedge PCLK);
            if (TX == 1'b0) seen = 1'b1;
        end
        chk("t1_start_seen", seen, 1'b1);
        len = 0;
        while (TX == 1'b0 && len < 200) begin
            len++;
            @(negedge PCLK);
        end
        chk("t1_start_len", len, 64);
        pat = 8'h55;
        repeat (32) @(negedge PCLK);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("t1_bit%0d", i), TX, pat[i]);
            repeat (64) @(negedge PCLK);
        end
        chk("t1_stop", TX, 1'b1);
        repeat (64) @(negedge PCLK);
        rd(5'h08, 16'h0021, "t1_status_idle");

        // Loopback, two characters.
        do_reset();
        loop = 1'b1;
        wr(5'h0C, 16'd0, "t2_baud");
        wr(5'h00, 16'h00A5, "t2_tx0");
        wr(5'h00, 16'h003C, "t2_tx1");
        repeat (400) @(negedge PCLK);
        rd(5'h08, 16'h0023, "t2_status");
        rd(5'h04, 16'h00A5, "t2_rx0");
        rd(5'h04, 16'h003C, "t2_rx1");
        rd(5'h04, 16'h0000, "t2_rx_empty");
        rd(5'h08, 16'h0021, "t2_status_empty");

        // TX FIFO overfill, then RX overflow with the 17th frame.
        do_reset();
        wr(5'h0C, 16'hFFFF, "t3_baud");
        for (int i = 0; i < 16; i++) wr(5'h00, 16'(i + 1), $sformatf("t3_push%0d", i));
        apb(1'b1, 5'h00, 16'h0077, r, e);
        chk("t3_full_err", e, 1'b1);
        rd(5'h08, 16'h0000, "t3_status_full");
        wr(5'h0C, 16'd0, "t3_baud_fast");
        repeat (2700) @(negedge PCLK);
        rd(5'h08, 16'h0023, "t4_status_16");
        wr(5'h00, 16'h0099, "t4_tx17");
        repeat (250) @(negedge PCLK);
        rd(5'h08, 16'h0027, "t4_status_ovf");
        rd(5'h08, 16'h0023, "t4_status_ovf_clr");
        wr(5'h10, 16'h0002, "t4_ie");
        chk("t4_irq_rxrdy", IRQ, 1'b1);
        for (int i = 0; i < 16; i++) rd(5'h04, 16'(i + 1), $sformatf("t4_rx%0d", i));
        rd(5'h04, 16'h0000, "t4_rx_empty");
        chk("t4_irq_off", IRQ, 1'b0);

        // Framing error, glitch rejection, then a clean frame.
        do_reset();
        loop = 1'b0;
        rx_drv = 1'b1;
        wr(5'h0C, 16'd0, "t5_baud");
        send_rx(8'h5A, 1'b0, 1'b0, 1'b0);
        rd(5'h08, 16'h0029, "t5_status_ferr");
        rd(5'h08, 16'h0021, "t5_status_clr");
        wr(5'h0C, 16'd3, "t5_baud3");
        rx_drv = 1'b0;
        repeat (4) @(negedge PCLK);
        rx_drv = 1'b1;
        repeat (100) @(negedge PCLK);
        rd(5'h08, 16'h0021, "t5_glitch");
        wr(5'h0C, 16'd0, "t5_baud0");
        send_rx(8'h5A, 1'b0, 1'b0, 1'b1);
        rd(5'h08, 16'h0023, "t5_status_ok");
        rd(5'h04, 16'h005A, "t5_rx");

`ifdef UART_PARITY_EN
        do_reset();
        wr(5'h0C, 16'd0, "t6_baud");
        wr(5'h10, 16'h0090, "t6_ctrl");
        send_rx(8'h07, 1'b1, 1'b0, 1'b1);
        chk("t6_irq", IRQ, 1'b1);
        rd(5'h08, 16'h0033, "t6_status_perr");
        rd(5'h04, 16'h0007, "t6_rx");
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
